// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multicycle control unit: state encoding,
// opcodes, ALU codes, datapath select codes and the decoded control word.
package ctrl_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OPC_W    = 4;
   localparam int unsigned FUNCT_W  = 3;
   localparam int unsigned ALU_OP_W = 3;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC_R = 4'd2,
      ST_WB_R   = 4'd3,
      ST_EXEC_I = 4'd4,
      ST_WB_I   = 4'd5,
      ST_MEM_RD = 4'd6,
      ST_WB_M   = 4'd7,
      ST_MEM_WR = 4'd8,
      ST_BRANCH = 4'd9,
      ST_JUMP   = 4'd10,
      ST_HALT   = 4'd11
`ifdef ILLEGAL_TRAP_EN
      , ST_TRAP = 4'd12
`endif
   } state_e;

   typedef enum logic [OPC_W-1:0] {
      OP_RTYPE = 4'b0000,
      OP_ADDI  = 4'b0001,
      OP_LW    = 4'b0010,
      OP_SW    = 4'b0011,
      OP_BEQ   = 4'b0100,
      OP_JMP   = 4'b0101,
      OP_HALT  = 4'b1111
   } opcode_e;

   // ALU operation codes, also used by the ALU itself
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_SHR  = 3'b010,
      ALU_SHL  = 3'b011,
      ALU_NAND = 3'b100,
      ALU_OR   = 3'b101,
      ALU_DIR  = 3'b110,
      ALU_SAR  = 3'b111
   } alu_op_e;

   typedef enum logic [SEL_W-1:0] {
      SRCB_REG  = 2'b00,
      SRCB_ONE  = 2'b01,
      SRCB_IMM  = 2'b10,
      SRCB_BOFF = 2'b11
   } src_b_e;

   typedef enum logic [SEL_W-1:0] {
      PCS_ALU    = 2'b00,
      PCS_ALUOUT = 2'b01,
      PCS_JUMP   = 2'b10
   } pc_src_e;

   typedef struct packed {
      logic                i_or_d;
      logic                mem_read;
      logic                mem_write;
      logic                ir_write;
      logic                reg_write;
      logic                reg_dst;
      logic                mem_to_reg;
      logic                alu_src_a;
      logic [SEL_W-1:0]    alu_src_b;
      logic [ALU_OP_W-1:0] alu_op;
      logic [SEL_W-1:0]    pc_source;
      logic                pc_write;
      logic                pc_write_cond;
      logic                halted;
      logic                illegal;
   } ctrl_out_t;

   function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
      return op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT};
   endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control-unit <-> datapath bundle: IR fields and zero flag in, strobes out.
interface mc_control_if;
   import ctrl_pkg::*;

   logic [OPC_W-1:0]    opcode;
   logic [FUNCT_W-1:0]  funct;
   logic                z;
   logic                pc_en;
   logic                i_or_d;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                reg_write;
   logic                reg_dst;
   logic                mem_to_reg;
   logic                alu_src_a;
   logic [SEL_W-1:0]    alu_src_b;
   logic [ALU_OP_W-1:0] alu_op;
   logic [SEL_W-1:0]    pc_source;
   logic                halted;
   logic                illegal;
   logic [STATE_W-1:0]  state;

   // Controller side
   modport master (
      input  opcode, funct, z,
      output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, halted,
             illegal, state
   );

   // Datapath side
   modport slave (
      output opcode, funct, z,
      input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, halted,
             illegal, state
   );
endinterface

// File: rtl/ctrl_out_decode.sv
// Moore output decode: maps the current state (plus funct/opcode) to the
// datapath control word. Optional ILLEGAL_TRAP_EN adds the TRAP state.
module ctrl_out_decode
   import ctrl_pkg::*;
#(
   parameter logic [SEL_W-1:0] PC_INC_SEL = SRCB_ONE
) (
   input  state_e              i_state,
   input  logic [FUNCT_W-1:0]  i_funct,
   input  logic [OPC_W-1:0]    i_opcode,
   output ctrl_out_t           o_ctrl_c
);

   always_comb begin
      o_ctrl_c        = '0;
      o_ctrl_c.alu_op = ALU_ADD;
      case (i_state)
         ST_FETCH: begin
            o_ctrl_c.mem_read  = 1'b1;
            o_ctrl_c.ir_write  = 1'b1;
            o_ctrl_c.alu_src_b = PC_INC_SEL;
            o_ctrl_c.pc_source = PCS_ALU;
            o_ctrl_c.pc_write  = 1'b1;
         end
         // Precompute the branch target into ALUOut while the opcode decodes
         ST_DECODE: begin
            o_ctrl_c.alu_src_b = SRCB_BOFF;
            o_ctrl_c.illegal   = ~is_legal_op(i_opcode);
         end
         ST_EXEC_R: begin
            o_ctrl_c.alu_src_a = 1'b1;
            o_ctrl_c.alu_src_b = SRCB_REG;
            o_ctrl_c.alu_op    = ALU_OP_W'(i_funct);
         end
         ST_WB_R: begin
            o_ctrl_c.reg_write = 1'b1;
            o_ctrl_c.reg_dst   = 1'b1;
         end
         ST_EXEC_I: begin
            o_ctrl_c.alu_src_a = 1'b1;
            o_ctrl_c.alu_src_b = SRCB_IMM;
         end
         ST_WB_I: o_ctrl_c.reg_write = 1'b1;
         ST_MEM_RD: begin
            o_ctrl_c.mem_read = 1'b1;
            o_ctrl_c.i_or_d   = 1'b1;
         end
         ST_WB_M: begin
            o_ctrl_c.reg_write  = 1'b1;
            o_ctrl_c.mem_to_reg = 1'b1;
         end
         ST_MEM_WR: begin
            o_ctrl_c.mem_write = 1'b1;
            o_ctrl_c.i_or_d    = 1'b1;
         end
         ST_BRANCH: begin
            o_ctrl_c.alu_src_a     = 1'b1;
            o_ctrl_c.alu_src_b     = SRCB_REG;
            o_ctrl_c.alu_op        = ALU_SUB;
            o_ctrl_c.pc_write_cond = 1'b1;
            o_ctrl_c.pc_source     = PCS_ALUOUT;
         end
         ST_JUMP: begin
            o_ctrl_c.pc_write  = 1'b1;
            o_ctrl_c.pc_source = PCS_JUMP;
         end
         ST_HALT: o_ctrl_c.halted = 1'b1;
`ifdef ILLEGAL_TRAP_EN
         ST_TRAP: o_ctrl_c.illegal = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle control unit: state register and next-state sequencing.
// Build option ILLEGAL_TRAP_EN parks illegal opcodes in a TRAP state.
module mc_control
   import ctrl_pkg::*;
#(
   parameter logic [SEL_W-1:0] PC_INC_SEL = SRCB_ONE
) (
   input logic          clk,
   input logic          rst,
   mc_control_if.master bus
);

   state_e    r_state;
   ctrl_out_t w_ctrl;
   ctrl_out_t w_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
      end else begin
         case (r_state)
            ST_FETCH:  r_state <= ST_DECODE;
            ST_DECODE: begin
               case (bus.opcode)
                  OP_RTYPE:                r_state <= ST_EXEC_R;
                  OP_ADDI, OP_LW, OP_SW:   r_state <= ST_EXEC_I;
                  OP_BEQ:                  r_state <= ST_BRANCH;
                  OP_JMP:                  r_state <= ST_JUMP;
                  OP_HALT:                 r_state <= ST_HALT;
`ifdef ILLEGAL_TRAP_EN
                  default:                 r_state <= ST_TRAP;
`else
                  default:                 r_state <= ST_FETCH;
`endif
               endcase
            end
            ST_EXEC_R: r_state <= ST_WB_R;
            ST_EXEC_I: begin
               case (bus.opcode)
                  OP_ADDI: r_state <= ST_WB_I;
                  OP_LW:   r_state <= ST_MEM_RD;
                  OP_SW:   r_state <= ST_MEM_WR;
                  default: r_state <= ST_FETCH;
               endcase
            end
            ST_MEM_RD: r_state <= ST_WB_M;
            ST_HALT:   r_state <= ST_HALT;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:   r_state <= ST_TRAP;
`endif
            default:   r_state <= ST_FETCH;
         endcase
      end
   end

   ctrl_out_decode #(
      .PC_INC_SEL (PC_INC_SEL)
   ) u_decode (
      .i_state  (r_state),
      .i_funct  (bus.funct),
      .i_opcode (bus.opcode),
      .o_ctrl_c (w_ctrl)
   );

   // Reset forces every output low, including the debug state
   assign w_out = rst ? '0 : w_ctrl;

   assign bus.pc_en      = w_out.pc_write | (w_out.pc_write_cond & bus.z);
   assign bus.i_or_d     = w_out.i_or_d;
   assign bus.mem_read   = w_out.mem_read;
   assign bus.mem_write  = w_out.mem_write;
   assign bus.ir_write   = w_out.ir_write;
   assign bus.reg_write  = w_out.reg_write;
   assign bus.reg_dst    = w_out.reg_dst;
   assign bus.mem_to_reg = w_out.mem_to_reg;
   assign bus.alu_src_a  = w_out.alu_src_a;
   assign bus.alu_src_b  = w_out.alu_src_b;
   assign bus.alu_op     = w_out.alu_op;
   assign bus.pc_source  = w_out.pc_source;
   assign bus.halted     = w_out.halted;
   assign bus.illegal    = w_out.illegal;
   assign bus.state      = rst ? STATE_W'(0) : STATE_W'(r_state);

endmodule
